alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with registered result and {N,Z,C,V} flags.
// Single-cycle ops (logic, add, subtract, pass-through) complete on the edge
// that accepts them. An optional unsigned shift-add multiply iterates one bit
// of B per cycle for WIDTH cycles.
//
// Build option: define ALU_MULTICYCLE_MUL_EN to build the multiplier
// (opcode 0, cmd 1001). Without it there is no BUSY state and cmd 1001
// behaves like any other undefined cmd.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request present           in_ready   request accepted this cycle
//   a, b       operands (WIDTH)          opcode     operation class (2)
//   cmd        operation in class (4)
//   out_valid  result/flags valid        out_ready  consumer takes result
//   result     registered result         flags      registered {N,Z,C,V}
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       opcode,
   input  logic [3:0]       cmd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

`ifdef ALU_MULTICYCLE_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

   state_t state;
   logic   accept;

   // Evaluates every single-cycle operation; returns {N,Z,C,V,result}.
   function automatic logic [WIDTH+3:0] alu_eval(
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y,
      input logic [1:0]       op,
      input logic [3:0]       c
   );
      logic [WIDTH:0]   sum;
      logic [WIDTH:0]   dab;
      logic [WIDTH:0]   dba;
      logic [WIDTH-1:0] r;
      logic             cf;
      logic             vf;
      sum = {1'b0, x} + {1'b0, y};
      // The extra top bit of a zero-extended difference is the borrow,
      // i.e. minuend < subtrahend unsigned.
      dab = {1'b0, x} - {1'b0, y};
      dba = {1'b0, y} - {1'b0, x};
      r   = '0;
      cf  = 1'b0;
      vf  = 1'b0;
      case (op)
         2'd0: begin
            case (c)
               4'b0000: r = x & y;
               4'b0001: r = x ^ y;
               4'b0010, 4'b1010: begin
                  r  = dab[WIDTH-1:0];
                  cf = dab[WIDTH];
                  vf = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
               end
               4'b0011: begin
                  r  = dba[WIDTH-1:0];
                  cf = dba[WIDTH];
                  vf = (y[WIDTH-1] != x[WIDTH-1]) && (r[WIDTH-1] != y[WIDTH-1]);
               end
               4'b0100: begin
                  r  = sum[WIDTH-1:0];
                  cf = sum[WIDTH];
                  vf = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
               end
               4'b1100: r = x | y;
               default: r = '0;
            endcase
         end
         2'd1:    r = c[3] ? sum[WIDTH-1:0] : x;
         2'd2:    r = sum[WIDTH-1:0];
         default: r = '0;
      endcase
      return {r[WIDTH-1], (r == '0), cf, vf, r};
   endfunction

   assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;

`ifdef ALU_MULTICYCLE_MUL_EN
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic               is_mul;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;

   assign is_mul = (opcode == 2'd0) && (cmd == 4'b1001);

   // Partial-product accumulate for the current multiplier bit.
   always_comb begin
      acc_nxt = acc;
      if (mplier[0]) acc_nxt = acc + mcand;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= 4'b0000;
`ifdef ALU_MULTICYCLE_MUL_EN
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
`endif
      end else begin
         case (state)
            IDLE, HOLD: begin
`ifdef ALU_MULTICYCLE_MUL_EN
               if (accept && is_mul) begin
                  state     <= BUSY;
                  out_valid <= 1'b0;
                  mcand     <= {{WIDTH{1'b0}}, a};
                  mplier    <= b;
                  acc       <= '0;
                  cnt       <= '0;
               end else
`endif
               if (accept) begin
                  state            <= HOLD;
                  out_valid        <= 1'b1;
                  {flags, result}  <= alu_eval(a, b, opcode, cmd);
               end else if ((state == HOLD) && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
`ifdef ALU_MULTICYCLE_MUL_EN
            BUSY: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               // Last bit of B: publish the finished product directly.
               if (cnt == LAST) begin
                  state     <= HOLD;
                  out_valid <= 1'b1;
                  result    <= acc_nxt[WIDTH-1:0];
                  flags     <= {acc_nxt[WIDTH-1], (acc_nxt[WIDTH-1:0] == '0),
                                (|acc_nxt[2*WIDTH-1:WIDTH]), 1'b0};
               end
            end
`endif
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
